fifo_sync_wm: RTL
=================

Name: fifo_sync_wm

Overview:
- Next-generation generic synchronous FIFO: ready/valid write and read ports, any Depth >= 1 (power of two not required).
- Adds runtime-programmable almost-full/almost-empty watermarks with one-cycle rise-event pulses.
- Adds an optional registered output stage for timing closure.
- Drop-in for peripheral RX/TX buffering and TL-UL adapter queues wherever watermark interrupts or a registered rdata path are needed.

Parameters:
- Width, 16, data bits per entry.
- Depth, 4, storage entries; must be >= 1; Depth 0 is illegal (elaboration error).
- Pass, 1, 1 = a write to an empty FIFO is readable the same cycle; honoured only when OutputReg = 0.
- OutputReg, 0, 1 = adds a one-entry output register; capacity becomes Depth+1.
- OutputZeroIfEmpty, 1, 1 = rdata_o forced to 0 while rvalid_o = 0.
- Cap (localparam), Depth+OutputReg, total capacity.
- DepthW (localparam), prim_util_pkg::vbits(Cap+1), occupancy width.

Ports:
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clr_i  in  1  synchronous flush.
- wvalid_i  in  1  write request.
- wready_o  out  1  write accept.
- wdata_i  in  Width  write data.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read accept.
- rdata_o  out  Width  read data.
- full_o  out  1  occupancy == Cap.
- empty_o  out  1  occupancy == 0.
- depth_o  out  DepthW  occupancy.
- afull_thresh_i  in  DepthW  almost-full level.
- aempty_thresh_i  in  DepthW  almost-empty level.
- afull_o  out  1  depth_o >= afull_thresh_i.
- aempty_o  out  1  depth_o <= aempty_thresh_i.
- afull_evt_o  out  1  one-cycle pulse on afull_o rising.
- aempty_evt_o  out  1  one-cycle pulse on aempty_o rising.
- perr_o  out  1  sticky parity error; present only with FIFO_SYNC_WM_PARITY_EN, tied 0 otherwise.

Behaviour:
- Reset values: pointers = 0, count = 0, output stage invalid, event history flops = 0.
  - Outputs in reset: wready_o = 0, rvalid_o = 0, rdata_o = 0, full_o = 0, empty_o = 1, depth_o = 0, evt outputs = 0, perr_o = 0.
- under_rst flag: set by reset, clears on the first clock after release. While set, wready_o = rvalid_o = 0 and no pointer moves.
- Handshakes:
  - Push = wvalid_i & wready_o, where wready_o = ~full & ~under_rst.
  - Pop = rvalid_o & rready_i.
  - wvalid_i while full is backpressure, not an error; wdata_i is ignored.
- Occupancy is a registered counter, not derived from the pointers:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - depth_o, full_o and empty_o come straight from the counter.
- Pointers are PTRV_W = vbits(Depth) bits and wrap from Depth-1 to 0. Full/empty are taken from the counter, so no extra MSB is needed.
- OutputReg = 0:
  - rvalid_o = (count != 0) or (Pass & wvalid_i & count == 0), gated by ~under_rst.
  - rdata_o = storage[rptr], or wdata_i in the pass case.
  - Pass push+pop on empty: no storage write, pointers and count unchanged.
- OutputReg = 1:
  - Output register ovld/odata; the head entry always resides there.
  - Refill ovld when it is empty or being popped: from storage if storage is non-empty, else from wdata_i on a push (bypassing storage).
  - Write-to-read latency is 1 cycle minimum; Pass is ignored.
  - count includes ovld.
- Watermarks:
  - afull_o and aempty_o are unsigned compares against the current depth_o, combinational from registers and the threshold inputs.
  - Thresholds may change at any time; a new threshold takes effect in the same cycle.
  - Threshold 0 makes afull_o constantly 1; a threshold >= Cap makes aempty_o constantly 1.
  - Each event output = flag & ~flag_q, where flag_q is registered each cycle. A flag already high when reset is released or clr_i deasserts pulses once.
- clr_i:
  - Next edge: pointers, count, ovld and flag_q go to 0; perr goes to 0.
  - clr_i wins over a simultaneous push/pop; the push is dropped.
  - The interface stays live; clr_i is not gated by under_rst.
- Async reset mid-transfer: all state is lost immediately; outputs take reset values combinationally.
- Storage array has no reset and is written only on push.

Optional Feature:
- FIFO_SYNC_WM_PARITY_EN defined:
  - Each entry stores Width+1 bits; the extra bit is the even parity of wdata_i.
  - On every pop, parity is recomputed over the delivered data. A mismatch sets perr_o (sticky until clr_i or reset).
  - Data is still delivered unchanged.
- Undefined: no extra storage bit, perr_o tied 0.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e (OutputReg choice).
  - Helper function for the pointer width (wraps prim_util_pkg::vbits).
  - Parity function par_even(data).
- Sub-module fifo_wm_ptr: parametrised Depth pointer with increment, wrap-at-Depth-1 and synchronous clear. Instantiated twice (write and read).

Test Plan:
- Reset release with wvalid_i = 1 → first cycle wready_o = 0; second cycle push accepted; depth_o = 1.
- Depth = 5, OutputReg = 0, Pass = 0: push 5 words 0x11..0x15 → full_o = 1 and wready_o = 0 after the 5th; pops return 0x11..0x15 in order; wrap verified with 3 further push/pop rounds.
- Pass = 1, empty, wvalid_i = rready_i = 1, wdata_i = 0xAB → same-cycle rdata_o = 0xAB, depth_o stays 0. With OutputReg = 1 → rvalid_o rises the next cycle with 0xAB.
- afull_thresh_i = 3, aempty_thresh_i = 1, Depth = 4:
  - Pushes 0→4: afull_evt_o pulses exactly once, on the cycle depth_o becomes 3.
  - Pops back to 1: aempty_evt_o pulses once, on the cycle depth_o becomes 1.
- clr_i asserted with depth_o = 3 and a simultaneous push → next cycle depth_o = 0, empty_o = 1, the pushed word is never read.
- FIFO_SYNC_WM_PARITY_EN: force a storage bit flip on entry 2 → perr_o rises on the pop of that entry and holds until clr_i.

Source files
------------

// File: rtl/fifo_sync_wm_pkg.sv
// Shared types and helpers for the watermark FIFO: output-stage mode, pointer
// width and even-parity helpers.
package fifo_pkg;

  typedef enum logic {
    MODE_COMB = 1'b0,
    MODE_REG  = 1'b1
  } fifo_mode_e;

  localparam int ParMaxW = 256;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int ptr_w(input int depth);
    return vbits(depth);
  endfunction

  function automatic logic par_even(input logic [ParMaxW-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_sync_wm_if.sv
// Write/read handshake bundle between a producer/consumer and fifo_sync_wm.
interface fifo_sync_wm_if #(
  parameter int Width = 16
) ();
  import fifo_pkg::*;

  // A beat transfers on any clock edge where valid and ready are both high;
  // valid never waits for ready, and data is only meaningful while valid is 1.
  logic             wvalid_i;
  logic             wready_o;
  logic [Width-1:0] wdata_i;
  logic             rvalid_o;
  logic             rready_i;
  logic [Width-1:0] rdata_o;

  modport master (
    output wvalid_i, wdata_i, rready_i,
    input  wready_o, rvalid_o, rdata_o
  );

  modport slave (
    input  wvalid_i, wdata_i, rready_i,
    output wready_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/fifo_sync_wm_ptr.sv
// Storage pointer counting 0..Depth-1 with wrap and synchronous clear.
module fifo_wm_ptr
  import fifo_pkg::*;
#(
  parameter  int Depth = 4,
  localparam int PtrW  = ptr_w(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [PtrW-1:0] ptr_o
);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == PtrW'(Depth - 1)) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_wm.sv
// Synchronous ready/valid FIFO with programmable almost-full/empty watermarks,
// optional output register and optional parity (FIFO_SYNC_WM_PARITY_EN).
module fifo_sync_wm
  import fifo_pkg::*;
#(
  parameter  int Width             = 16,
  parameter  int Depth             = 4,
  parameter  bit Pass              = 1'b1,
  parameter  bit OutputReg         = 1'b0,
  parameter  bit OutputZeroIfEmpty = 1'b1,
  localparam int Cap               = Depth + int'(OutputReg),
  localparam int DepthW            = vbits(Cap + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  fifo_sync_wm_if.slave     bus,
  output logic              full_o,
  output logic              empty_o,
  output logic [DepthW-1:0] depth_o,
  input  logic [DepthW-1:0] afull_thresh_i,
  input  logic [DepthW-1:0] aempty_thresh_i,
  output logic              afull_o,
  output logic              aempty_o,
  output logic              afull_evt_o,
  output logic              aempty_evt_o,
  output logic              perr_o
);

  localparam int PtrW = ptr_w(Depth);
  localparam fifo_mode_e Mode = OutputReg ? MODE_REG : MODE_COMB;
`ifdef FIFO_SYNC_WM_PARITY_EN
  localparam int EntryW = Width + 1;
`else
  localparam int EntryW = Width;
`endif

  if (Depth < 1) begin : g_bad_depth
    $error("fifo_sync_wm: Depth must be >= 1");
  end

  logic              under_rst_q;
  logic [DepthW-1:0] count_q, count_d;
  logic [PtrW-1:0]   wptr, rptr;
  logic [EntryW-1:0] mem_q [Depth];
  logic [EntryW-1:0] wentry, head;
  logic              full, empty, wready, rvalid, push, pop, mem_we, rptr_inc;
  logic              afull, aempty, afull_q, aempty_q;

  // Holds the interface quiet for the first clock after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) under_rst_q <= 1'b1;
    else         under_rst_q <= 1'b0;
  end

  assign full   = (count_q == DepthW'(Cap));
  assign empty  = (count_q == '0);
  assign wready = ~full & ~under_rst_q;
  assign push   = bus.wvalid_i & wready;
  assign pop    = rvalid & bus.rready_i;

`ifdef FIFO_SYNC_WM_PARITY_EN
  assign wentry = {par_even(ParMaxW'(bus.wdata_i)), bus.wdata_i};
`else
  assign wentry = bus.wdata_i;
`endif

  if (Mode == MODE_REG) begin : g_oreg
    logic              ovld_q, ovld_d, store_empty, refill, load_mem, load_w;
    logic [EntryW-1:0] odata_q, odata_d;
    logic [DepthW-1:0] store_cnt;

    // The head always lives in the output register; storage only holds the rest.
    always_comb begin
      store_cnt   = count_q - DepthW'(ovld_q);
      store_empty = (store_cnt == '0);
      refill      = ~ovld_q | pop;
      load_mem    = refill & ~store_empty;
      load_w      = refill & store_empty & push;
      ovld_d      = ovld_q;
      odata_d     = odata_q;
      if (load_mem) begin
        ovld_d  = 1'b1;
        odata_d = mem_q[rptr];
      end else if (load_w) begin
        ovld_d  = 1'b1;
        odata_d = wentry;
      end else if (refill) begin
        ovld_d  = 1'b0;
      end
      if (clr_i) ovld_d = 1'b0;
      rvalid   = ovld_q & ~under_rst_q;
      head     = odata_q;
      mem_we   = push & ~load_w & ~clr_i;
      rptr_inc = load_mem;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ovld_q  <= 1'b0;
        odata_q <= '0;
      end else begin
        ovld_q  <= ovld_d;
        odata_q <= odata_d;
      end
    end
  end else begin : g_comb
    logic bypass;

    always_comb begin
      rvalid   = ~under_rst_q & (~empty | (Pass & bus.wvalid_i));
      head     = (Pass && empty) ? wentry : mem_q[rptr];
      bypass   = Pass & empty & push & pop;
      mem_we   = push & ~bypass & ~clr_i;
      rptr_inc = pop & ~bypass;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_i)              count_d = '0;
    else if (push & ~pop)   count_d = count_q + DepthW'(1);
    else if (pop & ~push)   count_d = count_q - DepthW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  fifo_wm_ptr #(.Depth(Depth)) u_wptr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr_i),
    .inc_i (mem_we),
    .ptr_o (wptr)
  );

  fifo_wm_ptr #(.Depth(Depth)) u_rptr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr_i),
    .inc_i (rptr_inc),
    .ptr_o (rptr)
  );

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wptr] <= wentry;
  end

  assign afull  = (count_q >= afull_thresh_i);
  assign aempty = (count_q <= aempty_thresh_i);

  // History held at 0 through reset and clear so a flag already high pulses once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b0;
    end else if (clr_i | under_rst_q) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b0;
    end else begin
      afull_q  <= afull;
      aempty_q <= aempty;
    end
  end

`ifdef FIFO_SYNC_WM_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (clr_i) begin
      perr_d = 1'b0;
    end else if (pop && (par_even(ParMaxW'(head[Width-1:0])) != head[Width])) begin
      perr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perr_q <= 1'b0;
    else         perr_q <= perr_d;
  end

  assign perr_o = perr_q;
`else
  assign perr_o = 1'b0;
`endif

  assign bus.wready_o = wready;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = (OutputZeroIfEmpty && !rvalid) ? '0 : head[Width-1:0];
  assign full_o       = full;
  assign empty_o      = empty;
  assign depth_o      = count_q;
  assign afull_o      = afull;
  assign aempty_o     = aempty;
  assign afull_evt_o  = afull & ~afull_q & ~under_rst_q;
  assign aempty_evt_o = aempty & ~aempty_q & ~under_rst_q;

endmodule
